// File: rtl/adc_event_capture_pkg.sv
// Shared types for the ADC event capture block: record layout, readout
// framing constant, capture/readout state encodings and the header-word packer.
package adc_evt_pkg;

  localparam int         REC_W      = 80;
  localparam logic [7:0] WORD_MAGIC = 8'hA5;

  typedef struct packed {
    logic [63:0] ts;
    logic [15:0] peak;
  } evt_rec_t;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_TRACK,
    CAP_WAIT_LOW
  } cap_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_W0,
    RD_W1,
    RD_W2
  } rd_state_e;

  function automatic logic [31:0] make_w0(input logic [7:0] seq, input logic [15:0] peak);
    return {WORD_MAGIC, seq, peak};
  endfunction

endpackage

// File: rtl/adc_event_capture_if.sv
// Stream bundle for the capture block: valid-only trigger input from the ADC
// stage and the 32-bit AXI-Stream readout. The capture block is the master.
interface adc_event_capture_if;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/adc_event_fifo.sv
// Synchronous record FIFO with registered full/empty/level. Writes to a full
// FIFO and reads from an empty one are ignored.
module adc_event_fifo
  import adc_evt_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  evt_rec_t wr_data,
  input  logic     rd_en,
  output evt_rec_t rd_data,
  output logic     full,
  output logic     empty,
  output logic [AW:0] level
);
  localparam int DEPTH = 1 << AW;

  evt_rec_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && !full_q;
    do_rd    = rd_en && !empty_q;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_wr && !do_rd) level_d = level_q + (AW+1)'(1);
    if (do_rd && !do_wr) level_d = level_q - (AW+1)'(1);
    full_d   = (level_d == (AW+1)'(DEPTH));
    empty_d  = (level_d == '0);
  end

  // NOTE: storage is deliberately not reset; clearing the pointers makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/adc_event_capture.sv
// Captures trigger episodes (start timestamp + peak) into a record FIFO and
// serialises each record as three AXI-Stream words.
module adc_event_capture
  import adc_evt_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int MAX_TRACK = 4096
) (
  input  logic                 aclk,
  input  logic                 areset,
  adc_event_capture_if.master  axis,
  input  logic                 clear_counters,
  output logic [31:0]          event_count,
  output logic [15:0]          drop_count,
  output logic [FIFO_AW:0]     fifo_level
);
  localparam int LEN_W = $clog2(MAX_TRACK + 1);

  logic [63:0]      timestamp_q, timestamp_d;
  cap_state_e       cap_q, cap_d;
  logic [63:0]      ts_start_q, ts_start_d;
  logic [15:0]      peak_q, peak_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             close;
  logic [31:0]      event_count_q, event_count_d;
  logic [15:0]      drop_count_q, drop_count_d;

  rd_state_e        rd_q, rd_d;
  logic [63:0]      ts_hold_q, ts_hold_d;
  logic [7:0]       seq_q, seq_d;
  logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0]      tdata_q, tdata_d;
  logic             accept, load;

  logic             fifo_full, fifo_empty;
  evt_rec_t         fifo_rd_data;

  adc_event_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (close),
    .wr_data ({ts_start_q, peak_q}),
    .rd_en   (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    cap_d      = cap_q;
    ts_start_d = ts_start_q;
    peak_d     = peak_q;
    len_d      = len_q;
    close      = 1'b0;
    unique case (cap_q)
      CAP_IDLE: if (axis.s_axis_tvalid) begin
        cap_d      = CAP_TRACK;
        ts_start_d = timestamp_q;
        peak_d     = axis.s_axis_tdata;
        len_d      = LEN_W'(1);
      end
      CAP_TRACK: if (!axis.s_axis_tvalid) begin
        close = 1'b1;
        cap_d = CAP_IDLE;
      end else if (len_q == LEN_W'(MAX_TRACK)) begin
        close = 1'b1;
        cap_d = CAP_WAIT_LOW;
      end else begin
        if (axis.s_axis_tdata > peak_q) peak_d = axis.s_axis_tdata;
        len_d = len_q + LEN_W'(1);
      end
      CAP_WAIT_LOW: if (!axis.s_axis_tvalid) cap_d = CAP_IDLE;
      default: cap_d = CAP_IDLE;
    endcase

    timestamp_d = timestamp_q + 64'd1;
    // Full is the registered pre-pop flag, so a same-cycle pop never rescues a push.
    event_count_d = clear_counters ? '0 : event_count_q + 32'(close);
    drop_count_d  = drop_count_q;
    if (clear_counters)                                       drop_count_d = '0;
    else if (close && fifo_full && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_comb begin
    rd_d      = rd_q;
    ts_hold_d = ts_hold_q;
    seq_d     = seq_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    load      = 1'b0;
    accept    = tvalid_q && axis.m_axis_tready;
    unique case (rd_q)
      RD_IDLE: load = !fifo_empty;
      RD_W0: if (accept) begin
        rd_d    = RD_W1;
        tdata_d = ts_hold_q[63:32];
      end
      RD_W1: if (accept) begin
        rd_d    = RD_W2;
        tdata_d = ts_hold_q[31:0];
        tlast_d = 1'b1;
      end
      RD_W2: if (accept) begin
        load     = !fifo_empty;
        rd_d     = RD_IDLE;
        tvalid_d = 1'b0;
        tdata_d  = '0;
        tlast_d  = 1'b0;
      end
      default: rd_d = RD_IDLE;
    endcase
    // Back-to-back records reload straight into W0 so the stream has no bubble.
    if (load) begin
      rd_d      = RD_W0;
      ts_hold_d = fifo_rd_data.ts;
      seq_d     = seq_q + 8'd1;
      tvalid_d  = 1'b1;
      tdata_d   = make_w0(seq_q, fifo_rd_data.peak);
      tlast_d   = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      timestamp_q   <= '0;
      cap_q         <= CAP_IDLE;
      ts_start_q    <= '0;
      peak_q        <= '0;
      len_q         <= '0;
      event_count_q <= '0;
      drop_count_q  <= '0;
      rd_q          <= RD_IDLE;
      ts_hold_q     <= '0;
      seq_q         <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tlast_q       <= 1'b0;
    end else begin
      timestamp_q   <= timestamp_d;
      cap_q         <= cap_d;
      ts_start_q    <= ts_start_d;
      peak_q        <= peak_d;
      len_q         <= len_d;
      event_count_q <= event_count_d;
      drop_count_q  <= drop_count_d;
      rd_q          <= rd_d;
      ts_hold_q     <= ts_hold_d;
      seq_q         <= seq_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
    end
  end

  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tdata  = tdata_q;
  assign axis.m_axis_tlast  = tlast_q;
  assign event_count        = event_count_q;
  assign drop_count         = drop_count_q;

endmodule

// File: tb/tb_adc_event_capture.sv
// Directed bench for adc_event_capture: episode capture, forced close, FIFO
// overflow, stalled readout, counter clear and mid-record reset.
module tb_adc_event_capture;

  typedef struct {
    logic [63:0] ts;
    logic [15:0] peak;
  } rec_t;

  logic        clk = 1'b0;
  logic        areset;
  logic        clear_counters;
  logic [31:0] event_count;
  logic [15:0] drop_count;
  logic [4:0]  fifo_level;
  logic [63:0] cyc;

  int          checks = 0;
  int          errors = 0;
  rec_t        exp_q[$];
  logic [7:0]  exp_seq;

  adc_event_capture_if bus ();

  adc_event_capture #(.FIFO_AW(4), .MAX_TRACK(8)) dut (
    .aclk           (clk),
    .areset         (areset),
    .axis           (bus),
    .clear_counters (clear_counters),
    .event_count    (event_count),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the free-running counter holds in the current cycle.
  always @(posedge clk) begin
    if (areset) cyc <= '0;
    else        cyc <= cyc + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset             = 1'b1;
    bus.s_axis_tvalid  = 1'b0;
    bus.m_axis_tready  = 1'b0;
    clear_counters     = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
  endtask

  task automatic pulse(input logic [15:0] v, input bit keep);
    @(negedge clk);
    if (keep) exp_q.push_back('{ts: cyc, peak: v});
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = v;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
  endtask

  // Waits for a valid word, checks it, then completes the handshake and drops tready.
  task automatic expect_word(input string tag, input logic [31:0] exp_data, input logic exp_last,
                             input bit rnd, output int waited);
    bit done;
    int spins;
    done   = 1'b0;
    waited = 0;
    spins  = 0;
    while (!done) begin
      @(negedge clk);
      spins++;
      if (bus.m_axis_tvalid) begin
        check({tag, "_data"}, 64'(bus.m_axis_tdata), 64'(exp_data));
        check({tag, "_last"}, 64'(bus.m_axis_tlast), 64'(exp_last));
        bus.m_axis_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        done = bus.m_axis_tready;
      end else begin
        waited++;
      end
      if (!done && spins > 400) begin
        check({tag, "_timeout_tready"}, 64'(bus.m_axis_tready), 64'd1);
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.m_axis_tready = 1'b0;
  endtask

  task automatic drain_record(input bit rnd, input bit gapless);
    rec_t r;
    int   w0, w1, w2;
    if (exp_q.size() == 0) begin
      check("exp_queue_nonempty", 64'(exp_q.size()), 64'd1);
      return;
    end
    r = exp_q.pop_front();
    expect_word($sformatf("seq%0d_w0", exp_seq), {8'hA5, exp_seq, r.peak}, 1'b0, rnd, w0);
    expect_word($sformatf("seq%0d_w1", exp_seq), r.ts[63:32], 1'b0, rnd, w1);
    expect_word($sformatf("seq%0d_w2", exp_seq), r.ts[31:0], 1'b1, rnd, w2);
    if (gapless) check($sformatf("seq%0d_gap", exp_seq), 64'(w0 + w1 + w2), 64'd0);
    exp_seq++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int   w;
    rec_t r;
    areset            = 1'b1;
    clear_counters    = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;

    // Reset state
    do_reset();
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_tdata",  64'(bus.m_axis_tdata),  64'd0);
    check("rst_tlast",  64'(bus.m_axis_tlast),  64'd0);
    check("rst_events", 64'(event_count),       64'd0);
    check("rst_drops",  64'(drop_count),        64'd0);
    check("rst_level",  64'(fifo_level),        64'd0);

    // Test 1: episode at cycles 10..14, peak 12, start timestamp 10
    while (cyc != 64'd10) @(negedge clk);
    exp_q.push_back('{ts: 64'd10, peak: 16'd12});
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 16'd5;
    @(negedge clk); bus.s_axis_tdata = 16'd9;
    @(negedge clk); bus.s_axis_tdata = 16'd3;
    @(negedge clk); bus.s_axis_tdata = 16'd12;
    @(negedge clk); bus.s_axis_tdata = 16'd7;
    @(negedge clk); bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("t1_tvalid_n1", 64'(bus.m_axis_tvalid), 64'd0);
    @(negedge clk);
    check("t1_tvalid_n2", 64'(bus.m_axis_tvalid), 64'd1);
    check("t1_events",    64'(event_count),       64'd1);
    drain_record(1'b0, 1'b0);

    // Test 2: 20-cycle hold with MAX_TRACK=8; only the first 8 samples count
    @(negedge clk);
    exp_q.push_back('{ts: cyc, peak: 16'd17});
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 16'd10;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      bus.s_axis_tdata = (i < 8) ? 16'(10 + i) : 16'd100;
      if (i == 12) check("t2_events_forced", 64'(event_count), 64'd2);
    end
    @(negedge clk); bus.s_axis_tvalid = 1'b0;
    drain_record(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("t2_no_extra_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("t2_no_extra_events", 64'(event_count),       64'd2);
    pulse(16'h0055, 1'b1);
    @(negedge clk);
    check("t2_rearm_events", 64'(event_count), 64'd3);
    drain_record(1'b0, 1'b0);

    // Test 3: overflow with readout stalled, then gapless drain
    do_reset();
    for (int k = 0; k < 18; k++) pulse(16'(100 + k), k < 17);
    repeat (3) @(negedge clk);
    check("t3_level",  64'(fifo_level),  64'd16);
    check("t3_drops",  64'(drop_count),  64'd1);
    check("t3_events", 64'(event_count), 64'd18);
    for (int k = 0; k < 17; k++) drain_record(1'b0, 1'b1);
    @(negedge clk);
    check("t3_level_empty", 64'(fifo_level),       64'd0);
    check("t3_tvalid_idle", 64'(bus.m_axis_tvalid), 64'd0);

    // Test 4: random backpressure over three records
    pulse(16'h1234, 1'b1);
    pulse(16'h00FF, 1'b1);
    pulse(16'hFFFE, 1'b1);
    for (int k = 0; k < 3; k++) drain_record(1'b1, 1'b0);

    // Test 5: clear_counters in the closing cycle
    @(negedge clk);
    exp_q.push_back('{ts: cyc, peak: 16'h0042});
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 16'h0042;
    @(negedge clk);
    bus.s_axis_tdata  = 16'h0040;
    @(negedge clk);
    check("t5_events_before", 64'(event_count), 64'd21);
    check("t5_drops_before",  64'(drop_count),  64'd1);
    bus.s_axis_tvalid = 1'b0;
    clear_counters    = 1'b1;
    @(negedge clk);
    clear_counters    = 1'b0;
    check("t5_events_cleared", 64'(event_count), 64'd0);
    check("t5_drops_cleared",  64'(drop_count),  64'd0);
    drain_record(1'b0, 1'b0);

    // Test 6: reset while W1 is presented with two records queued
    pulse(16'h0A0A, 1'b1);
    pulse(16'h0B0B, 1'b1);
    pulse(16'h0C0C, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_level_queued", 64'(fifo_level), 64'd2);
    r = exp_q[0];
    expect_word("t6_w0", {8'hA5, exp_seq, r.peak}, 1'b0, 1'b0, w);
    @(negedge clk);
    check("t6_w1_data", 64'(bus.m_axis_tdata), 64'(r.ts[63:32]));
    areset = 1'b1;
    @(negedge clk);
    check("t6_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("t6_rst_level",  64'(fifo_level),        64'd0);
    check("t6_rst_events", 64'(event_count),       64'd0);
    check("t6_rst_tdata",  64'(bus.m_axis_tdata),  64'd0);
    areset = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
    pulse(16'h0123, 1'b1);
    drain_record(1'b0, 1'b0);
    check("t6_events_after", 64'(event_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
